// File: rtl/wbuffer_pkg.sv
// Shared types for the weight buffer and its controller: the buffer opcode
// encoding and the controller state set.
package wbuffer_pkg;

    // Opcodes understood by the four-entry weight buffer.
    typedef enum logic [2:0] {
        WB_NOP   = 3'b000,
        WB_LD_W1 = 3'b001,  // SRAM word  -> w_1
        WB_LD_W2 = 3'b010,  // SRAM word  -> w_2
        WB_LD_W3 = 3'b011,  // SDRAM word -> w_3
        WB_LD_W4 = 3'b100,  // SDRAM word -> w_4
        WB_SHIFT = 3'b101   // w_2 -> w_1, w_4 -> w_3
    } wb_mode_t;

    // Controller states. LD1/LD3 fill the current pair, LD2/LD4 the next one.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LD1,
        S_LD3,
        S_LD2,
        S_LD4,
        S_READY,
        S_SHIFT
    } wbc_state_t;

endpackage

// File: rtl/wbuffer_ctrl.sv
// Weight buffer sequencer: fetches weight pairs (one SRAM word, one SDRAM
// word each) through req/ack handshakes and steers them into the buffer so
// that w_1/w_3 hold the current pair and w_2/w_4 the next pair.
module wbuffer_ctrl
    import wbuffer_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] sram_base,
    input  logic [ADDR_W-1:0] sdram_base,
    input  logic [ADDR_W-1:0] num_pairs,
    input  logic              advance,
    output logic              sram_req,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic              sram_ack,
    output logic              sdram_req,
    output logic [ADDR_W-1:0] sdram_addr,
    input  logic              sdram_ack,
    output logic              enable_CU,
    output logic [2:0]        mode,
    output logic              ready,
    output logic              busy,
    output logic              done
);

    wbc_state_t        state, state_nxt;
    wb_mode_t          mode_e;
    logic [ADDR_W-1:0] sram_base_q, sdram_base_q, num_q;
    logic [ADDR_W-1:0] fetch_idx, cons_idx;
    logic [ADDR_W-1:0] fetch_nxt, cons_nxt;
    logic              accept, fetch_inc, cons_inc, done_set, done_q;
    logic              in_load;

    assign fetch_nxt = fetch_idx + ADDR_W'(1);
    assign cons_nxt  = cons_idx + ADDR_W'(1);

    // State register, pair counters and the registered done pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state     <= S_IDLE;
            fetch_idx <= '0;
            cons_idx  <= '0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_set;
            if (accept) begin
                fetch_idx <= '0;
                cons_idx  <= '0;
            end else begin
                if (fetch_inc) fetch_idx <= fetch_nxt;
                if (cons_inc)  cons_idx  <= cons_nxt;
            end
        end
    end

    // Pass parameters captured when a start is accepted.
    always_ff @(posedge clk) begin
        // NOTE: these registers have no reset on purpose; they are written on
        // every accepted start and only read in states reachable after one.
        if (accept) begin
            sram_base_q  <= sram_base;
            sdram_base_q <= sdram_base;
            num_q        <= num_pairs;
        end
    end

    // Next-state, handshake and buffer opcode decode.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt = state;
        accept    = 1'b0;
        fetch_inc = 1'b0;
        cons_inc  = 1'b0;
        done_set  = 1'b0;
        sram_req  = 1'b0;
        sdram_req = 1'b0;
        enable_CU = 1'b0;
        mode_e    = WB_NOP;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_pairs == '0) begin
                        done_set = 1'b1;          // empty pass: done only
                    end else begin
                        accept    = 1'b1;
                        state_nxt = S_LD1;
                    end
                end
            end
            S_LD1: begin
                sram_req = 1'b1;
                mode_e   = WB_LD_W1;
                if (sram_ack) begin
                    enable_CU = 1'b1;
                    state_nxt = S_LD3;
                end
            end
            S_LD3: begin
                sdram_req = 1'b1;
                mode_e    = WB_LD_W3;
                if (sdram_ack) begin
                    enable_CU = 1'b1;
                    fetch_inc = 1'b1;
                    state_nxt = (fetch_nxt < num_q) ? S_LD2 : S_READY;
                end
            end
            S_LD2: begin
                sram_req = 1'b1;
                mode_e   = WB_LD_W2;
                if (sram_ack) begin
                    enable_CU = 1'b1;
                    state_nxt = S_LD4;
                end
            end
            S_LD4: begin
                sdram_req = 1'b1;
                mode_e    = WB_LD_W4;
                if (sdram_ack) begin
                    enable_CU = 1'b1;
                    fetch_inc = 1'b1;
                    state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (advance) begin
                    cons_inc = 1'b1;
                    if (cons_nxt == num_q) begin
                        done_set  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                enable_CU = 1'b1;
                mode_e    = WB_SHIFT;
                // Refill the next-pair slots only while unfetched pairs remain.
                state_nxt = (fetch_idx < num_q) ? S_LD2 : S_READY;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign in_load = (state == S_LD1) || (state == S_LD2) ||
                     (state == S_LD3) || (state == S_LD4);

    // Addresses wrap silently modulo 2^ADDR_W.
    assign sram_addr  = in_load ? (sram_base_q + fetch_idx)  : '0;
    assign sdram_addr = in_load ? (sdram_base_q + fetch_idx) : '0;

    assign mode  = mode_e;
    assign ready = (state == S_READY);
    assign busy  = (state != S_IDLE);
    assign done  = done_q;

endmodule

// File: tb/tb_wbuffer_ctrl.sv
// Directed testbench for wbuffer_ctrl. Memories answer with a programmable
// number of wait cycles; a behavioural copy of the weight buffer consumes
// the opcodes so buffer contents can be compared with hand-derived values.
module tb_wbuffer_ctrl;

    logic        clk, rst, start, advance;
    logic [15:0] sram_base, sdram_base, num_pairs;
    logic        sram_req, sdram_req, sram_ack, sdram_ack;
    logic [15:0] sram_addr, sdram_addr;
    logic        enable_CU, ready, busy, done;
    logic [2:0]  mode;

    int n_cmp = 0;
    int n_err = 0;
    int sram_wait = 0;
    int sdram_wait = 0;

    logic [15:0] w1, w2, w3, w4;

    // Expected control vector: {busy, ready, done, sram_req, sdram_req, enable_CU, mode}
    localparam logic [8:0] C_IDLE  = 9'b000_000_000;
    localparam logic [8:0] C_DONE  = 9'b001_000_000;
    localparam logic [8:0] C_READY = 9'b110_000_000;
    localparam logic [8:0] C_SHIFT = 9'b100_001_101;
    localparam logic [8:0] C_LD1_A = 9'b100_101_001;
    localparam logic [8:0] C_LD1_W = 9'b100_100_001;
    localparam logic [8:0] C_LD3_A = 9'b100_011_011;
    localparam logic [8:0] C_LD3_W = 9'b100_010_011;
    localparam logic [8:0] C_LD2_A = 9'b100_101_010;
    localparam logic [8:0] C_LD2_W = 9'b100_100_010;
    localparam logic [8:0] C_LD4_A = 9'b100_011_100;
    localparam logic [8:0] C_LD4_W = 9'b100_010_100;

    // Row flags: drive advance, drive start, drive rst during that cycle.
    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_ADV  = 3'b100;
    localparam logic [2:0] F_ST   = 3'b010;
    localparam logic [2:0] F_RS   = 3'b001;

    typedef struct {
        logic [8:0]  ctl;
        logic [15:0] sa, da;
        bit          ms, md;
        bit          adv, st, rs;
        bit          bw;
        logic [15:0] e1, e3;
    } row_t;

    wbuffer_ctrl #(.ADDR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sram_base  (sram_base),
        .sdram_base (sdram_base),
        .num_pairs  (num_pairs),
        .advance    (advance),
        .sram_req   (sram_req),
        .sram_addr  (sram_addr),
        .sram_ack   (sram_ack),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .enable_CU  (enable_CU),
        .mode       (mode),
        .ready      (ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a function of address.
    function automatic logic [15:0] sd(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction
    function automatic logic [15:0] dd(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3C3;
    endfunction

    // Behavioural weight buffer.
    always @(posedge clk) begin
        if (enable_CU) begin
            case (mode)
                3'b001: w1 <= sd(sram_addr);
                3'b010: w2 <= sd(sram_addr);
                3'b011: w3 <= dd(sdram_addr);
                3'b100: w4 <= dd(sdram_addr);
                3'b101: begin w1 <= w2; w3 <= w4; end
                default: ;
            endcase
        end
    end

    // Memory responders: ack after the configured number of wait cycles.
    initial begin
        int s_cnt, d_cnt;
        s_cnt = 0; d_cnt = 0;
        sram_ack = 1'b0; sdram_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            sram_ack = 1'b0; sdram_ack = 1'b0;
            if (sram_req) begin
                if (s_cnt == sram_wait) begin sram_ack = 1'b1; s_cnt = 0; end
                else s_cnt++;
            end else s_cnt = 0;
            if (sdram_req) begin
                if (d_cnt == sdram_wait) begin sdram_ack = 1'b1; d_cnt = 0; end
                else d_cnt++;
            end else d_cnt = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [8:0] obs();
        return {busy, ready, done, sram_req, sdram_req, enable_CU, mode};
    endfunction

    function automatic row_t mk(input logic [8:0] c, input logic [2:0] f);
        row_t r;
        r.ctl = c; r.sa = '0; r.da = '0; r.ms = 1'b1; r.md = 1'b1;
        r.adv = f[2]; r.st = f[1]; r.rs = f[0];
        r.bw = 1'b0; r.e1 = '0; r.e3 = '0;
        return r;
    endfunction
    function automatic row_t rs_(input logic [8:0] c, input logic [15:0] a, input logic [2:0] f);
        row_t r = mk(c, f);
        r.md = 1'b0; r.sa = a;
        return r;
    endfunction
    function automatic row_t rd_(input logic [8:0] c, input logic [15:0] a, input logic [2:0] f);
        row_t r = mk(c, f);
        r.ms = 1'b0; r.da = a;
        return r;
    endfunction
    function automatic row_t rr(input logic [2:0] f, input logic [15:0] e1, input logic [15:0] e3);
        row_t r = mk(C_READY, f);
        r.bw = 1'b1; r.e1 = e1; r.e3 = e3;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        n_cmp++;
        if (obs() !== C_IDLE) begin
            n_err++; $display("FAIL reset.ctl: got %b want %b", obs(), C_IDLE);
        end
        n_cmp++;
        if ({sram_addr, sdram_addr} !== 32'h0) begin
            n_err++; $display("FAIL reset.addr: got %h/%h want 0000/0000", sram_addr, sdram_addr);
        end
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_zero_wait();
        row_t q[$];
        q.push_back(rs_(C_LD1_A, 16'h0100, F_NONE));
        q.push_back(rd_(C_LD3_A, 16'h2000, F_NONE));
        q.push_back(rs_(C_LD2_A, 16'h0101, F_NONE));
        q.push_back(rd_(C_LD4_A, 16'h2001, F_NONE));
        q.push_back(rr(F_ADV, sd(16'h0100), dd(16'h2000)));
        q.push_back(mk(C_SHIFT, F_NONE));
        q.push_back(rs_(C_LD2_A, 16'h0102, F_NONE));
        q.push_back(rd_(C_LD4_A, 16'h2002, F_NONE));
        q.push_back(rr(F_ADV, sd(16'h0101), dd(16'h2001)));
        q.push_back(mk(C_SHIFT, F_NONE));
        q.push_back(rr(F_ADV, sd(16'h0102), dd(16'h2002)));
        q.push_back(mk(C_DONE, F_NONE));
        q.push_back(mk(C_IDLE, F_NONE));
        sram_wait = 0; sdram_wait = 0;
        sram_base = 16'h0100; sdram_base = 16'h2000; num_pairs = 16'd3; start = 1'b1;
        next_cycle();
        foreach (q[i]) begin
            advance = q[i].adv; start = q[i].st; rst = q[i].rs;
            #1;
            n_cmp++;
            if (obs() !== q[i].ctl) begin n_err++; $display("FAIL zero_wait.ctl cyc %0d: got %b want %b", i + 1, obs(), q[i].ctl); end
            if (q[i].ms) begin n_cmp++; if (sram_addr !== q[i].sa) begin n_err++; $display("FAIL zero_wait.sram_addr cyc %0d: got %h want %h", i + 1, sram_addr, q[i].sa); end end
            if (q[i].md) begin n_cmp++; if (sdram_addr !== q[i].da) begin n_err++; $display("FAIL zero_wait.sdram_addr cyc %0d: got %h want %h", i + 1, sdram_addr, q[i].da); end end
            if (q[i].bw) begin n_cmp++; if ({w1, w3} !== {q[i].e1, q[i].e3}) begin n_err++; $display("FAIL zero_wait.buffer cyc %0d: got %h/%h want %h/%h", i + 1, w1, w3, q[i].e1, q[i].e3); end end
            next_cycle();
        end
        advance = 1'b0; start = 1'b0; rst = 1'b0;
    endtask

    task automatic test_wait_states();
        row_t q[$];
        repeat (3) q.push_back(rs_(C_LD1_W, 16'h0300, F_NONE));
        q.push_back(rs_(C_LD1_A, 16'h0300, F_NONE));
        repeat (5) q.push_back(rd_(C_LD3_W, 16'h4000, F_NONE));
        q.push_back(rd_(C_LD3_A, 16'h4000, F_NONE));
        repeat (3) q.push_back(rs_(C_LD2_W, 16'h0301, F_NONE));
        q.push_back(rs_(C_LD2_A, 16'h0301, F_NONE));
        repeat (5) q.push_back(rd_(C_LD4_W, 16'h4001, F_NONE));
        q.push_back(rd_(C_LD4_A, 16'h4001, F_NONE));
        q.push_back(rr(F_ADV, sd(16'h0300), dd(16'h4000)));
        q.push_back(mk(C_SHIFT, F_NONE));
        q.push_back(rr(F_ADV, sd(16'h0301), dd(16'h4001)));
        q.push_back(mk(C_DONE, F_NONE));
        q.push_back(mk(C_IDLE, F_NONE));
        sram_wait = 3; sdram_wait = 5;
        sram_base = 16'h0300; sdram_base = 16'h4000; num_pairs = 16'd2; start = 1'b1;
        next_cycle();
        foreach (q[i]) begin
            advance = q[i].adv; start = q[i].st; rst = q[i].rs;
            #1;
            n_cmp++;
            if (obs() !== q[i].ctl) begin n_err++; $display("FAIL wait_states.ctl cyc %0d: got %b want %b", i + 1, obs(), q[i].ctl); end
            if (q[i].ms) begin n_cmp++; if (sram_addr !== q[i].sa) begin n_err++; $display("FAIL wait_states.sram_addr cyc %0d: got %h want %h", i + 1, sram_addr, q[i].sa); end end
            if (q[i].md) begin n_cmp++; if (sdram_addr !== q[i].da) begin n_err++; $display("FAIL wait_states.sdram_addr cyc %0d: got %h want %h", i + 1, sdram_addr, q[i].da); end end
            if (q[i].bw) begin n_cmp++; if ({w1, w3} !== {q[i].e1, q[i].e3}) begin n_err++; $display("FAIL wait_states.buffer cyc %0d: got %h/%h want %h/%h", i + 1, w1, w3, q[i].e1, q[i].e3); end end
            next_cycle();
        end
        advance = 1'b0; start = 1'b0; rst = 1'b0;
        sram_wait = 0; sdram_wait = 0;
    endtask

    // N=0 gives a bare done pulse; a start in that done cycle runs an N=1 pass.
    task automatic test_n0_n1();
        row_t q[$];
        q.push_back(mk(C_DONE, F_ST));
        q.push_back(rs_(C_LD1_A, 16'h0500, F_NONE));
        q.push_back(rd_(C_LD3_A, 16'h6000, F_NONE));
        q.push_back(rr(F_ADV, sd(16'h0500), dd(16'h6000)));
        q.push_back(mk(C_DONE, F_NONE));
        q.push_back(mk(C_IDLE, F_NONE));
        sram_base = 16'h0500; sdram_base = 16'h6000; num_pairs = 16'd0; start = 1'b1;
        next_cycle();
        num_pairs = 16'd1;
        foreach (q[i]) begin
            advance = q[i].adv; start = q[i].st; rst = q[i].rs;
            #1;
            n_cmp++;
            if (obs() !== q[i].ctl) begin n_err++; $display("FAIL n0_n1.ctl cyc %0d: got %b want %b", i + 1, obs(), q[i].ctl); end
            if (q[i].ms) begin n_cmp++; if (sram_addr !== q[i].sa) begin n_err++; $display("FAIL n0_n1.sram_addr cyc %0d: got %h want %h", i + 1, sram_addr, q[i].sa); end end
            if (q[i].md) begin n_cmp++; if (sdram_addr !== q[i].da) begin n_err++; $display("FAIL n0_n1.sdram_addr cyc %0d: got %h want %h", i + 1, sdram_addr, q[i].da); end end
            if (q[i].bw) begin n_cmp++; if ({w1, w3} !== {q[i].e1, q[i].e3}) begin n_err++; $display("FAIL n0_n1.buffer cyc %0d: got %h/%h want %h/%h", i + 1, w1, w3, q[i].e1, q[i].e3); end end
            next_cycle();
        end
        advance = 1'b0; start = 1'b0; rst = 1'b0;
    endtask

    // advance in LD2/SHIFT/IDLE and start while busy (with new bases) must do nothing.
    task automatic test_ignored_inputs();
        row_t q[$];
        q.push_back(rs_(C_LD1_A, 16'h0700, F_ST));
        q.push_back(rd_(C_LD3_A, 16'h7000, F_NONE));
        q.push_back(rs_(C_LD2_A, 16'h0701, F_ADV | F_ST));
        q.push_back(rd_(C_LD4_A, 16'h7001, F_NONE));
        q.push_back(rr(F_ADV, sd(16'h0700), dd(16'h7000)));
        q.push_back(mk(C_SHIFT, F_ADV));
        q.push_back(rr(F_NONE, sd(16'h0701), dd(16'h7001)));
        q.push_back(rr(F_ADV, sd(16'h0701), dd(16'h7001)));
        q.push_back(mk(C_DONE, F_NONE));
        q.push_back(mk(C_IDLE, F_ADV));
        q.push_back(mk(C_IDLE, F_NONE));
        sram_base = 16'h0700; sdram_base = 16'h7000; num_pairs = 16'd2; start = 1'b1;
        next_cycle();
        sram_base = 16'hBEEF; sdram_base = 16'hCAFE; num_pairs = 16'd9;
        foreach (q[i]) begin
            advance = q[i].adv; start = q[i].st; rst = q[i].rs;
            #1;
            n_cmp++;
            if (obs() !== q[i].ctl) begin n_err++; $display("FAIL ignored.ctl cyc %0d: got %b want %b", i + 1, obs(), q[i].ctl); end
            if (q[i].ms) begin n_cmp++; if (sram_addr !== q[i].sa) begin n_err++; $display("FAIL ignored.sram_addr cyc %0d: got %h want %h", i + 1, sram_addr, q[i].sa); end end
            if (q[i].md) begin n_cmp++; if (sdram_addr !== q[i].da) begin n_err++; $display("FAIL ignored.sdram_addr cyc %0d: got %h want %h", i + 1, sdram_addr, q[i].da); end end
            if (q[i].bw) begin n_cmp++; if ({w1, w3} !== {q[i].e1, q[i].e3}) begin n_err++; $display("FAIL ignored.buffer cyc %0d: got %h/%h want %h/%h", i + 1, w1, w3, q[i].e1, q[i].e3); end end
            next_cycle();
        end
        advance = 1'b0; start = 1'b0; rst = 1'b0;
    endtask

    // rst while LD4 is waiting on SDRAM, then a fresh start from pair 0.
    task automatic test_reset_midflight();
        row_t q[$];
        q.push_back(rs_(C_LD1_A, 16'h0900, F_NONE));
        q.push_back(rd_(C_LD3_W, 16'hA000, F_NONE));
        q.push_back(rd_(C_LD3_W, 16'hA000, F_NONE));
        q.push_back(rd_(C_LD3_A, 16'hA000, F_NONE));
        q.push_back(rs_(C_LD2_A, 16'h0901, F_NONE));
        q.push_back(rd_(C_LD4_W, 16'hA001, F_RS));
        q.push_back(mk(C_IDLE, F_ST));
        q.push_back(rs_(C_LD1_A, 16'h0900, F_NONE));
        q.push_back(rd_(C_LD3_W, 16'hA000, F_RS));
        q.push_back(mk(C_IDLE, F_NONE));
        sram_wait = 0; sdram_wait = 2;
        sram_base = 16'h0900; sdram_base = 16'hA000; num_pairs = 16'd3; start = 1'b1;
        next_cycle();
        foreach (q[i]) begin
            advance = q[i].adv; start = q[i].st; rst = q[i].rs;
            #1;
            n_cmp++;
            if (obs() !== q[i].ctl) begin n_err++; $display("FAIL rst_mid.ctl cyc %0d: got %b want %b", i + 1, obs(), q[i].ctl); end
            if (q[i].ms) begin n_cmp++; if (sram_addr !== q[i].sa) begin n_err++; $display("FAIL rst_mid.sram_addr cyc %0d: got %h want %h", i + 1, sram_addr, q[i].sa); end end
            if (q[i].md) begin n_cmp++; if (sdram_addr !== q[i].da) begin n_err++; $display("FAIL rst_mid.sdram_addr cyc %0d: got %h want %h", i + 1, sdram_addr, q[i].da); end end
            if (q[i].bw) begin n_cmp++; if ({w1, w3} !== {q[i].e1, q[i].e3}) begin n_err++; $display("FAIL rst_mid.buffer cyc %0d: got %h/%h want %h/%h", i + 1, w1, w3, q[i].e1, q[i].e3); end end
            next_cycle();
        end
        advance = 1'b0; start = 1'b0; rst = 1'b0;
        sram_wait = 0; sdram_wait = 0;
    endtask

    task automatic test_addr_wrap();
        row_t q[$];
        q.push_back(rs_(C_LD1_A, 16'hFFFF, F_NONE));
        q.push_back(rd_(C_LD3_A, 16'hFFFE, F_NONE));
        q.push_back(rs_(C_LD2_A, 16'h0000, F_NONE));
        q.push_back(rd_(C_LD4_A, 16'hFFFF, F_NONE));
        q.push_back(rr(F_ADV, sd(16'hFFFF), dd(16'hFFFE)));
        q.push_back(mk(C_SHIFT, F_NONE));
        q.push_back(rr(F_ADV, sd(16'h0000), dd(16'hFFFF)));
        q.push_back(mk(C_DONE, F_NONE));
        q.push_back(mk(C_IDLE, F_NONE));
        sram_base = 16'hFFFF; sdram_base = 16'hFFFE; num_pairs = 16'd2; start = 1'b1;
        next_cycle();
        foreach (q[i]) begin
            advance = q[i].adv; start = q[i].st; rst = q[i].rs;
            #1;
            n_cmp++;
            if (obs() !== q[i].ctl) begin n_err++; $display("FAIL wrap.ctl cyc %0d: got %b want %b", i + 1, obs(), q[i].ctl); end
            if (q[i].ms) begin n_cmp++; if (sram_addr !== q[i].sa) begin n_err++; $display("FAIL wrap.sram_addr cyc %0d: got %h want %h", i + 1, sram_addr, q[i].sa); end end
            if (q[i].md) begin n_cmp++; if (sdram_addr !== q[i].da) begin n_err++; $display("FAIL wrap.sdram_addr cyc %0d: got %h want %h", i + 1, sdram_addr, q[i].da); end end
            if (q[i].bw) begin n_cmp++; if ({w1, w3} !== {q[i].e1, q[i].e3}) begin n_err++; $display("FAIL wrap.buffer cyc %0d: got %h/%h want %h/%h", i + 1, w1, w3, q[i].e1, q[i].e3); end end
            next_cycle();
        end
        advance = 1'b0; start = 1'b0; rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; advance = 1'b0;
        sram_base = '0; sdram_base = '0; num_pairs = '0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_n0_n1();
        test_ignored_inputs();
        test_reset_midflight();
        test_addr_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
